// File: rtl/frame_scheduler.sv
// Per-frame task sequencer: on the trigger line it starts up to four tasks in order and waits for each one's done.
// Define FRAME_SCHEDULER_TIMEOUT_EN to add a per-task watchdog that flags and skips a stalled task.
module frame_scheduler #(
  parameter int unsigned TRIGGER_LINE   = 515,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] h_pos,
  input  logic [15:0] v_pos,
  input  logic [3:0]  task_en,
  input  logic [3:0]  done_i,
  input  logic        err_clr,
  output logic [3:0]  start_o,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic [3:0]  timeout_err
);

  typedef enum logic [1:0] {IDLE, SEL, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        overrun_q, overrun_d;
  logic        trig;
  logic        tmo_hit;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("frame_scheduler: TIMEOUT_CYCLES must be at least 2");
  end

  assign trig = (h_pos == 16'd0) && (v_pos == 16'(TRIGGER_LINE));

`ifdef FRAME_SCHEDULER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]    tmo_err_q, tmo_err_d;

  // Watchdog fires only when the current task's done is absent, so a same-cycle done wins.
  assign tmo_hit = (state_q == WAIT) && !done_i[slot_q] &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    if (err_clr) tmo_err_d = 4'b0000;
    if (state_q == SEL) tmo_cnt_d = '0;
    else if (state_q == WAIT) tmo_cnt_d = tmo_cnt_q + TW'(1);
    if (tmo_hit) tmo_err_d[slot_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 4'b0000;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 4'b0000;
`endif

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    frame_cnt_d = frame_cnt_q;
    start_o     = 4'b0000;
    overrun_d   = overrun_q;
    if (err_clr) overrun_d = 1'b0;
    if (trig && (state_q != IDLE)) overrun_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (trig) begin
          slot_d  = 2'd0;
          state_d = SEL;
        end
      end
      SEL: begin
        if (task_en[slot_q]) begin
          start_o[slot_q] = 1'b1;
          state_d         = WAIT;
        end else if (slot_q == 2'd3) begin
          state_d = DONE;
        end else begin
          slot_d = slot_q + 2'd1;
        end
      end
      WAIT: begin
        if (done_i[slot_q] || tmo_hit) begin
          if (slot_q == 2'd3) begin
            state_d = DONE;
          end else begin
            slot_d  = slot_q + 2'd1;
            state_d = SEL;
          end
        end
      end
      DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= 2'd0;
      frame_cnt_q <= 16'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;

endmodule
